mem_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/mem_array.sv | 39 +++
 rtl/mem_responder.sv | 156 +++++++++++++++
 tb/tb_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
//   Shared types for the data-memory responder:
//   - state_t   : responder FSM states
//   - mem_req_t : request register captured at acceptance
//   - DEF_ADDR_W / DEF_DATA_W : default widths. The request struct is sized
//     from these, so the top-level width parameters must match them.
package mem_resp_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// mem_array
//   Single-port synchronous RAM with registered read data. The read register
//   only updates on a read strobe, so it holds the last loaded word.
// Ports:
//   clk    in  rising-edge clock
//   we     in  write enable (writes wdata to mem[addr])
//   re     in  read enable (rdata <= mem[addr] at the edge)
//   addr   in  word index
//   wdata  in  write data
//   rdata  out registered read data
module mem_array #(
  parameter int DEPTH     = 256,
  parameter int DATA_W    = 16,
  parameter     INIT_FILE = "data.txt",
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Data-memory responder for the CPU load/store port. Accepts one request
//   at a time, inserts WAIT_CYCLES wait states, performs the RAM access in a
//   single cycle, then presents the response until the CPU takes it.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_write             1 = store, 0 = load
//   req_addr, req_wdata   word address and store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             load data, or echoed store data
//   rsp_err               request address was >= DEPTH
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = "data.txt"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (ADDR_W != DEF_ADDR_W || DATA_W != DEF_DATA_W) begin : g_width_chk
    $error("mem_responder: ADDR_W/DATA_W must match mem_resp_pkg defaults");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_depth_chk
    $error("mem_responder: DEPTH exceeds address space");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_from_ram_q, rsp_from_ram_d;
  logic              in_range;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign in_range = ({1'b0, req_q.addr} < DEPTH_L);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_d          = req_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    rsp_from_ram_d = rsp_from_ram_q;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d.write = req_write;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_LOAD);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACCESS: begin
        state_d   = RESP;
        rsp_err_d = ~in_range;
        if (req_q.write) begin
          // A store that meets reset on this edge must not land in memory.
          ram_we         = in_range & rst_n;
          rsp_rdata_d    = req_q.wdata;
          rsp_from_ram_d = 1'b0;
        end else begin
          // In-range loads are served straight from the RAM read register;
          // out-of-range loads return the zeroed local register.
          ram_re         = in_range;
          rsp_rdata_d    = '0;
          rsp_from_ram_d = in_range;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d   = IDLE;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_from_ram_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      rsp_from_ram_q <= rsp_from_ram_d;
    end
  end

  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  mem_array #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .INIT_FILE(INIT_FILE)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (req_q.addr[IDX_W-1:0]),
    .wdata(req_q.wdata),
    .rdata(ram_rdata)
  );

  assign rsp_rdata = rsp_from_ram_q ? ram_rdata : rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder. Instance 0 runs with two wait states,
//   instance 1 with none; both implement 64 words so address 200 is out of
//   range. Memory contents are set up through stores.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [1:0]  rsp_ready;
  logic [7:0]  req_addr  [2];
  logic [15:0] req_wdata [2];
  wire  [1:0]  req_ready;
  wire  [1:0]  rsp_valid;
  wire  [1:0]  rsp_err;
  wire  [15:0] rsp_rdata [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W(8), .DATA_W(16), .DEPTH(64), .WAIT_CYCLES(2), .INIT_FILE("")
  ) u_dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(
    .ADDR_W(8), .DATA_W(16), .DEPTH(64), .WAIT_CYCLES(0), .INIT_FILE("")
  ) u_dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present a request at a negedge once the responder is ready, hold it over
  // the accepting edge, then scramble the request inputs.
  task automatic issue(input int d, input logic wr, input logic [7:0] addr, input logic [15:0] wd);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("issue_ready", 32'(ok), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d]  = ~addr;
    req_wdata[d] = ~wd;
  endtask

  // Full transaction with rsp_ready held high. lat counts edges from the
  // accepting edge (edge 1) to the edge that raised rsp_valid; busy counts
  // cycles with req_ready low.
  task automatic txn(input int d, input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                     output logic [15:0] rd, output logic er, output int lat, output int busy);
    logic done;
    int   k;
    rd = '0; er = 1'b0; lat = 0; busy = 0; done = 1'b0; k = 1;
    issue(d, wr, addr, wd);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!req_ready[d]) busy++;
      if (rsp_valid[d] && lat == 0) begin
        lat = k;
        rd  = rsp_rdata[d];
        er  = rsp_err[d];
      end
      if (req_ready[d]) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      k++;
    end
    check_eq("txn_done", 32'(done), 32'd1);
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat, busy;
  logic        saw_valid, got;

  initial begin
    req_valid = '0;
    req_write = '0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_req_ready", 32'(req_ready[0]), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata[0]), 32'h0);
    check_eq("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
    check_eq("rst_req_ready_w0", 32'(req_ready[1]), 32'd1);

    // Memory setup
    txn(0, 1'b1, 8'd5, 16'hD7C8, rd, er, lat, busy);
    check_eq("pre_store_echo", 32'(rd), 32'hD7C8);
    txn(0, 1'b1, 8'd3, 16'd55, rd, er, lat, busy);
    txn(0, 1'b1, 8'd7, 16'h0005, rd, er, lat, busy);
    txn(0, 1'b1, 8'd8, 16'h0BEE, rd, er, lat, busy);

    // Load with two wait states
    txn(0, 1'b0, 8'd5, 16'h0000, rd, er, lat, busy);
    check_eq("ld5_data", 32'(rd), 32'hD7C8);
    check_eq("ld5_err", 32'(er), 32'd0);
    check_eq("ld5_latency", 32'(lat), 32'd4);
    check_eq("ld5_busy", 32'(busy), 32'd4);

    // Store then load, same address
    txn(0, 1'b1, 8'd10, 16'hFFC8, rd, er, lat, busy);
    check_eq("st10_echo", 32'(rd), 32'hFFC8);
    check_eq("st10_err", 32'(er), 32'd0);
    txn(0, 1'b0, 8'd10, 16'h0000, rd, er, lat, busy);
    check_eq("ld10_data", 32'(rd), 32'hFFC8);

    // Backpressure
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 8'd3, 16'h0000);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("bp_rsp_seen", 32'(got), 32'd1);
    for (int j = 0; j < 5; j++) begin
      check_eq("bp_valid_held", 32'(rsp_valid[0]), 32'd1);
      check_eq("bp_data_held", 32'(rsp_rdata[0]), 32'd55);
      @(negedge clk);
    end
    check_eq("bp_valid_before_ready", 32'(rsp_valid[0]), 32'd1);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check_eq("bp_valid_cleared", 32'(rsp_valid[0]), 32'd0);
    check_eq("bp_req_ready", 32'(req_ready[0]), 32'd1);
    check_eq("bp_data_kept", 32'(rsp_rdata[0]), 32'd55);

    // Out of range (DEPTH = 64); address 200 aliases index 8 if not gated
    txn(0, 1'b1, 8'd200, 16'h1234, rd, er, lat, busy);
    check_eq("oor_st_err", 32'(er), 32'd1);
    check_eq("oor_err_clears", 32'(rsp_err[0]), 32'd0);
    txn(0, 1'b0, 8'd200, 16'h0000, rd, er, lat, busy);
    check_eq("oor_ld_err", 32'(er), 32'd1);
    check_eq("oor_ld_data", 32'(rd), 32'h0);
    txn(0, 1'b0, 8'd8, 16'h0000, rd, er, lat, busy);
    check_eq("oor_no_alias", 32'(rd), 32'h0BEE);
    check_eq("oor_alias_err", 32'(er), 32'd0);

    // Reset during WAIT abandons the store
    saw_valid = 1'b0;
    issue(0, 1'b1, 8'd7, 16'hAAAA);
    @(negedge clk);
    saw_valid |= rsp_valid[0];
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rstw_req_ready", 32'(req_ready[0]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      saw_valid |= rsp_valid[0];
      @(negedge clk);
    end
    check_eq("rstw_no_rsp", 32'(saw_valid), 32'd0);
    txn(0, 1'b0, 8'd7, 16'h0000, rd, er, lat, busy);
    check_eq("rstw_ld7", 32'(rd), 32'h0005);

    // Reset coinciding with the ACCESS edge also drops the store
    saw_valid = 1'b0;
    issue(0, 1'b1, 8'd7, 16'h5A5A);
    repeat (3) begin
      @(negedge clk);
      saw_valid |= rsp_valid[0];
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      saw_valid |= rsp_valid[0];
      @(negedge clk);
    end
    check_eq("rsta_no_rsp", 32'(saw_valid), 32'd0);
    txn(0, 1'b0, 8'd7, 16'h0000, rd, er, lat, busy);
    check_eq("rsta_ld7", 32'(rd), 32'h0005);

    // Zero wait states, back-to-back loads
    txn(1, 1'b1, 8'd0, 16'h1111, rd, er, lat, busy);
    check_eq("w0_st_latency", 32'(lat), 32'd2);
    txn(1, 1'b1, 8'd1, 16'h2222, rd, er, lat, busy);
    txn(1, 1'b0, 8'd0, 16'h0000, rd, er, lat, busy);
    check_eq("w0_ld0_data", 32'(rd), 32'h1111);
    check_eq("w0_ld0_latency", 32'(lat), 32'd2);
    check_eq("w0_ld0_busy", 32'(busy), 32'd2);
    txn(1, 1'b0, 8'd1, 16'h0000, rd, er, lat, busy);
    check_eq("w0_ld1_data", 32'(rd), 32'h2222);
    check_eq("w0_ld1_latency", 32'(lat), 32'd2);
    check_eq("w0_ld1_busy", 32'(busy), 32'd2);
    check_eq("w0_ld1_err", 32'(er), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
